region_scan_selector: RTL
=========================

Name: region_scan_selector

Overview:
Parametrised successor to the fixed 1-of-4 coordinate selector. It maps a (column, row) matrix coordinate to a region index over a REGIONS_X × REGIONS_Y grid and registers the result. It scans all regions time-multiplexed to drive the region demux select, and generates a blinking cursor flag for the selected region. It sits between the game/coordinate logic and the LED-matrix region demultiplexers.

Parameters:
COORD_W, 3, width of column and row coordinates
RGN_W_LOG2, 2, log2 of region width in columns
RGN_H_LOG2, 2, log2 of region height in rows
REGIONS_X, 2, regions per row of the grid (≥1)
REGIONS_Y, 2, regions per column of the grid (≥1)
SCAN_DIV, 1000, clk cycles per scan step (≥2)
BLINK_DIV, 25, full scan frames per blink phase (≥1)
(derived) NREG = REGIONS_X*REGIONS_Y; SEL_W = max(1, clog2(NREG))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
col_in  in  COORD_W  coordinate column
row_in  in  COORD_W  coordinate row
coord_valid  in  1  load request for col_in/row_in, sampled every cycle
clear  in  1  drop the selected region
blink_en  in  1  1 = cursor blinks, 0 = cursor steady on
dmx_sel  out  SEL_W  region currently being scanned (demux select)
scan_tick  out  1  one-cycle pulse on each scan step
region_idx  out  SEL_W  registered selected region
region_valid  out  1  region_idx holds a valid selection
out_of_range  out  1  one-cycle pulse when a load is rejected
cursor_on  out  1  the scanned region is the selected one and the cursor is lit

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, with priority over all inputs. A reset asserted mid-operation returns every register to its reset value on that edge.
- Reset values: dmx_sel=0, scan_tick=0, region_idx=0, region_valid=0, out_of_range=0, cursor_on=0, prescaler=0, frame counter=0, cursor FSM=NONE.
- Region mapping: rx = col_in >> RGN_W_LOG2; ry = row_in >> RGN_H_LOG2. The load is in range iff rx < REGIONS_X and ry < REGIONS_Y. region = ry*REGIONS_X + rx, truncated to SEL_W.
- Load, latency 1:
  - coord_valid high and in range: region_idx=region on the next edge.
  - coord_valid high and out of range: out_of_range=1 for one cycle. region_idx, region_valid and the FSM are unchanged.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count: scan_tick=1 for that cycle, and dmx_sel advances on the same edge. dmx_sel wraps from NREG-1 to 0.
  - A frame completes when dmx_sel wraps. The scan free-runs and is never disturbed by load or clear.
- Cursor FSM states: NONE (region_valid=0), ON, OFF. region_valid=1 in ON and OFF.
  - NONE → ON on an accepted load; the frame counter clears.
  - ON → OFF when blink_en=1 and BLINK_DIV frames have completed since entering ON; the frame counter clears.
  - OFF → ON after BLINK_DIV frames, or on the next edge if blink_en=0.
  - ON/OFF → ON on an accepted load; the frame counter restarts and region_idx updates.
  - Any state → NONE on clear.
  - clear and coord_valid in the same cycle: clear wins, and no out_of_range pulse is issued.
- cursor_on = (state==ON) && (dmx_sel==region_idx). It is combinational from registers and adds no extra latency.
- NREG=1: dmx_sel stays 0 and a frame completes on every scan_tick.
- All arithmetic is unsigned. The region product is computed at SEL_W+COORD_W bits before truncation.

Decomposition:
- Package region_scan_pkg holds:
  - cursor state encoding (NONE=2'd0, ON=2'd1, OFF=2'd2)
  - a clog2 helper function
  - the SEL_W derivation rule
- Sub-module scan_prescaler (modulo-N counter with terminal-count tick, parameter DIV) is instantiated once for the scan step. Frame and blink counting stay inline.

Test Plan:
Bench parameters: SCAN_DIV=4, BLINK_DIV=2, default grid.
1. Reset: hold rst for 3 cycles, then release. All outputs are 0; the first scan_tick appears 4 cycles after release; dmx_sel runs 0→1→2→3→0.
2. Load mapping: col=5, row=2 with coord_valid for 1 cycle. Next cycle region_idx=1 and region_valid=1; cursor_on=1 only while dmx_sel=1.
3. Out of range: set REGIONS_X=1, load col=4, row=0. out_of_range pulses 1 cycle; region_idx and region_valid keep their prior values.
4. Blink, blink_en=1, region 3 loaded: the cursor stays ON for 2 frames (32 cycles), then OFF for 2 frames. With blink_en=0 while OFF, the FSM returns to ON next cycle.
5. clear and coord_valid (col=0, row=7) in the same cycle: the FSM goes to NONE, region_valid=0, cursor_on stays 0, and there is no out_of_range pulse.
6. rst asserted mid-frame with dmx_sel=2 and the FSM in OFF: the next edge restores all reset values; the scan restarts from 0.

Source files
------------

// File: rtl/region_scan_selector_pkg.sv
// Shared definitions for the region scan selector: cursor state encoding
// and width helpers used to size the select and counter buses.
package region_scan_pkg;

  typedef enum logic [1:0] {
    CUR_NONE = 2'd0,
    CUR_ON   = 2'd1,
    CUR_OFF  = 2'd2
  } cursor_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single-region grid still needs a 1-bit select bus.
  function automatic int sel_width(input int nreg);
    return (nreg <= 1) ? 1 : clog2(nreg);
  endfunction

endpackage

// File: rtl/region_scan_selector_prescaler.sv
// Modulo-DIV free-running counter; tick_o is high during the terminal count.
module scan_prescaler
  import region_scan_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = sel_width(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CW'(DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/region_scan_selector.sv
// Maps a matrix coordinate to a region index, scans all regions for the
// demux select and flags the selected region with a blinking cursor.
module region_scan_selector
  import region_scan_pkg::*;
#(
  parameter int COORD_W    = 3,
  parameter int RGN_W_LOG2 = 2,
  parameter int RGN_H_LOG2 = 2,
  parameter int REGIONS_X  = 2,
  parameter int REGIONS_Y  = 2,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 25
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [COORD_W-1:0]                            col_in,
  input  logic [COORD_W-1:0]                            row_in,
  input  logic                                          coord_valid,
  input  logic                                          clear,
  input  logic                                          blink_en,
  output logic [sel_width(REGIONS_X*REGIONS_Y)-1:0]     dmx_sel,
  output logic                                          scan_tick,
  output logic [sel_width(REGIONS_X*REGIONS_Y)-1:0]     region_idx,
  output logic                                          region_valid,
  output logic                                          out_of_range,
  output logic                                          cursor_on
);

  localparam int NREG  = REGIONS_X * REGIONS_Y;
  localparam int SEL_W = sel_width(NREG);
  localparam int PW    = SEL_W + COORD_W;
  localparam int FW    = sel_width(BLINK_DIV + 1);

  cursor_state_e state_q;
  logic [SEL_W-1:0] dmx_q, idx_q, region_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [COORD_W-1:0] rx, ry;
  logic oor_q, in_range, load_ok, frame_done, blink_due;

  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(scan_tick)
  );

  always_comb begin
    rx         = col_in >> RGN_W_LOG2;
    ry         = row_in >> RGN_H_LOG2;
    in_range   = (32'(rx) < 32'(REGIONS_X)) && (32'(ry) < 32'(REGIONS_Y));
    region_d   = SEL_W'(PW'(ry) * PW'(REGIONS_X) + PW'(rx));
    load_ok    = coord_valid && in_range;
    frame_done = scan_tick && (dmx_q == SEL_W'(NREG - 1));
    // Frame count saturates so a long steady phase still blinks promptly once enabled.
    frame_d    = (frame_done && frame_q != FW'(BLINK_DIV)) ? frame_q + 1'b1 : frame_q;
    blink_due  = (frame_d == FW'(BLINK_DIV));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmx_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      frame_q <= '0;
      state_q <= CUR_NONE;
    end else begin
      oor_q <= coord_valid && !clear && !in_range;
      if (scan_tick) dmx_q <= (dmx_q == SEL_W'(NREG - 1)) ? '0 : dmx_q + 1'b1;

      if (clear) begin
        state_q <= CUR_NONE;
        frame_q <= '0;
      end else if (load_ok) begin
        state_q <= CUR_ON;
        frame_q <= '0;
        idx_q   <= region_d;
      end else begin
        unique case (state_q)
          CUR_ON: begin
            if (blink_en && blink_due) begin
              state_q <= CUR_OFF;
              frame_q <= '0;
            end else begin
              frame_q <= frame_d;
            end
          end
          CUR_OFF: begin
            if (!blink_en || blink_due) begin
              state_q <= CUR_ON;
              frame_q <= '0;
            end else begin
              frame_q <= frame_d;
            end
          end
          default: frame_q <= frame_q;
        endcase
      end
    end
  end

  always_comb begin
    dmx_sel      = dmx_q;
    region_idx   = idx_q;
    region_valid = (state_q != CUR_NONE);
    out_of_range = oor_q;
    cursor_on    = (state_q == CUR_ON) && (dmx_q == idx_q);
  end

endmodule
